// File: rtl/ldst_ctrl.sv
// Load/store sequencer: effective-address generation, memory req/ack handshake and
// Rd/Rn register writeback. Optional memory-wait timeout is enabled by LDST_TIMEOUT_EN.
module ldst_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        start,
    input  logic        L,
    input  logic        Bsel,
    input  logic        U,
    input  logic        P,
    input  logic        W,
    input  logic [31:0] rn_val,
    input  logic [31:0] off_val,
    input  logic [31:0] st_data,
    input  logic [3:0]  rd_addr,
    input  logic [3:0]  rn_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        busy,
    output logic        done,
    output logic        abort
);

    typedef enum logic [2:0] {IDLE, ADDR, MREQ, WB_RD, WB_RN, DONE} state_t;

    state_t state, state_nxt;

    logic        l_r, b_r, u_r, p_r, w_r;
    logic [31:0] rn_r, off_r, st_r;
    logic [3:0]  rd_addr_r, rn_addr_r;
    logic [31:0] oa_r, ea_r, ld_r;

    logic        wb;
    logic [31:0] oa_calc;
    logic [31:0] ld_calc;
    logic        timeout_hit;

    assign wb      = !p_r | w_r;
    assign oa_calc = u_r ? (rn_r + off_r) : (rn_r - off_r);

    // Byte loads keep only the addressed lane, zero-extended.
    always_comb begin
        ld_calc = mem_rdata;
        if (b_r) begin
            case (ea_r[1:0])
                2'd0:    ld_calc = {24'h0, mem_rdata[7:0]};
                2'd1:    ld_calc = {24'h0, mem_rdata[15:8]};
                2'd2:    ld_calc = {24'h0, mem_rdata[23:16]};
                default: ld_calc = {24'h0, mem_rdata[31:24]};
            endcase
        end
    end

`ifdef LDST_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          abort_r;

    assign timeout_hit = !mem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (Rst) begin
            wait_cnt <= '0;
            abort_r  <= 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    wait_cnt <= '0;
                    abort_r  <= 1'b0;
                end
                MREQ: begin
                    if (!mem_ack) wait_cnt <= wait_cnt + 1'b1;
                    if (timeout_hit) abort_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign abort = (state == DONE) && abort_r;
`else
    // Parameter only matters when the timeout counter is built.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign abort          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Rst) begin
            state     <= IDLE;
            l_r       <= 1'b0;
            b_r       <= 1'b0;
            u_r       <= 1'b0;
            p_r       <= 1'b0;
            w_r       <= 1'b0;
            rn_r      <= '0;
            off_r     <= '0;
            st_r      <= '0;
            rd_addr_r <= '0;
            rn_addr_r <= '0;
            oa_r      <= '0;
            ea_r      <= '0;
            ld_r      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        l_r       <= L;
                        b_r       <= Bsel;
                        u_r       <= U;
                        p_r       <= P;
                        w_r       <= W;
                        rn_r      <= rn_val;
                        off_r     <= off_val;
                        st_r      <= st_data;
                        rd_addr_r <= rd_addr;
                        rn_addr_r <= rn_addr;
                    end
                end
                ADDR: begin
                    oa_r <= oa_calc;
                    ea_r <= p_r ? oa_calc : rn_r;
                end
                MREQ: begin
                    if (mem_ack) ld_r <= ld_calc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ADDR;
            ADDR:  state_nxt = MREQ;
            MREQ: begin
                if (mem_ack) begin
                    if (l_r)     state_nxt = WB_RD;
                    else if (wb) state_nxt = WB_RN;
                    else         state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            // Equal indices: the loaded value wins, base writeback is dropped.
            WB_RD: state_nxt = (wb && (rn_addr_r != rd_addr_r)) ? WB_RN : DONE;
            WB_RN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        reg_we    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            MREQ: begin
                mem_req = 1'b1;
                mem_we  = !l_r;
                if (b_r) begin
                    mem_addr  = ea_r;
                    mem_be    = 4'b0001 << ea_r[1:0];
                    mem_wdata = {4{st_r[7:0]}};
                end else begin
                    mem_addr  = {ea_r[31:2], 2'b00};
                    mem_be    = 4'b1111;
                    mem_wdata = st_r;
                end
            end
            WB_RD: begin
                reg_we    = 1'b1;
                reg_waddr = rd_addr_r;
                reg_wdata = ld_r;
            end
            WB_RN: begin
                reg_we    = 1'b1;
                reg_waddr = rn_addr_r;
                reg_wdata = oa_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldst_ctrl.sv
// Scoreboard bench for ldst_ctrl: directed cases plus randomized transfers against a
// behavioural address/lane model; timeout cases are built when LDST_TIMEOUT_EN is defined.
module tb_ldst_ctrl;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic        L = 1'b0, Bsel = 1'b0, U = 1'b0, P = 1'b0, W = 1'b0;
    logic [31:0] rn_val = '0, off_val = '0, st_data = '0;
    logic [3:0]  rd_addr = '0, rn_addr = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy, done, abort;

    ldst_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .Rst(Rst), .start(start), .L(L), .Bsel(Bsel), .U(U), .P(P), .W(W),
        .rn_val(rn_val), .off_val(off_val), .st_data(st_data),
        .rd_addr(rd_addr), .rn_addr(rn_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .busy(busy), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } reg_exp_t;

    typedef struct {
        int   start_edge;
        int   cycles;
        logic abort;
    } done_exp_t;

    mem_exp_t  mem_q[$];
    reg_exp_t  reg_q[$];
    done_exp_t done_q[$];

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: compares every memory beat, register write and completion against the queues.
    always @(negedge clk) begin
        if (!Rst) begin
            if (mem_ack) begin
                checkOutput("mem_req_at_ack", {31'b0, mem_req}, 32'd1);
                if (mem_req) begin
                    if (mem_q.size() == 0) begin
                        checkOutput("mem_unexpected", 32'd1, 32'd0);
                    end else begin
                        mem_exp_t m;
                        m = mem_q.pop_front();
                        checkOutput("mem_addr", mem_addr, m.addr);
                        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                        checkOutput("mem_be", {28'b0, mem_be}, {28'b0, m.be});
                        checkOutput("mem_wdata", mem_wdata, m.wdata);
                    end
                end
            end
            if (reg_we) begin
                if (reg_q.size() == 0) begin
                    checkOutput("reg_we_unexpected", {28'b0, reg_waddr}, 32'hFFFF_FFFF);
                end else begin
                    reg_exp_t r;
                    r = reg_q.pop_front();
                    checkOutput("reg_waddr", {28'b0, reg_waddr}, {28'b0, r.idx});
                    checkOutput("reg_wdata", reg_wdata, r.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checkOutput("done_unexpected", 32'd1, 32'd0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    checkOutput("done_cycles", edge_cnt - d.start_edge + 1, d.cycles);
                    checkOutput("abort", {31'b0, abort}, {31'b0, d.abort});
                end
            end
            if (abort && !done) checkOutput("abort_without_done", 32'd1, 32'd0);
        end
    end

    // Pulses start from the current post-edge point; returns the start edge index.
    task automatic issueStart(input logic l, input logic b, input logic u, input logic p, input logic w,
                              input logic [31:0] rn, input logic [31:0] off, input logic [31:0] st,
                              input logic [3:0] rda, input logic [3:0] rna, output int e0);
        start = 1'b1;
        L = l; Bsel = b; U = u; P = p; W = w;
        rn_val = rn; off_val = off; st_data = st; rd_addr = rda; rn_addr = rna;
        @(posedge clk); #1;
        e0 = edge_cnt;
        start = 1'b0;
        L = $urandom; Bsel = $urandom; U = $urandom; P = $urandom; W = $urandom;
        rn_val = $urandom; off_val = $urandom; st_data = $urandom;
        rd_addr = 4'($urandom); rn_addr = 4'($urandom);
        checkOutput("busy_in_addr", {31'b0, busy}, 32'd1);
        checkOutput("no_req_in_addr", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic waitDone();
        int k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        checkOutput("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input logic l, input logic b, input logic u, input logic p, input logic w,
                                 input logic [31:0] rn, input logic [31:0] off, input logic [31:0] st,
                                 input logic [3:0] rda, input logic [3:0] rna,
                                 input int waits, input logic [31:0] rdata);
        logic [31:0] oa, ea, ldata;
        logic        wb;
        mem_exp_t    m;
        reg_exp_t    r;
        done_exp_t   d;
        int          e0;
        int          nwr;
        oa = u ? rn + off : rn - off;
        ea = p ? oa : rn;
        wb = !p || w;
        m.addr  = b ? ea : {ea[31:2], 2'b00};
        m.we    = !l;
        m.be    = b ? (4'b0001 << ea[1:0]) : 4'b1111;
        m.wdata = b ? {4{st[7:0]}} : st;
        mem_q.push_back(m);
        ldata = b ? ((rdata >> (8 * ea[1:0])) & 32'h0000_00FF) : rdata;
        nwr = 0;
        if (l) begin
            r.idx = rda; r.data = ldata; reg_q.push_back(r); nwr++;
        end
        if (wb && !(l && rna == rda)) begin
            r.idx = rna; r.data = oa; reg_q.push_back(r); nwr++;
        end
        issueStart(l, b, u, p, w, rn, off, st, rda, rna, e0);
        d.start_edge = e0;
        d.cycles     = 3 + waits + nwr;
        d.abort      = 1'b0;
        done_q.push_back(d);
        @(posedge clk); #1;
        for (int i = 0; i <= waits; i++) begin
            mem_ack   = (i == waits);
            mem_rdata = (i == waits) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        waitDone();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0;
        Rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_be", {28'b0, mem_be}, 32'd0);
        checkOutput("rst_reg_we", {31'b0, reg_we}, 32'd0);
        checkOutput("rst_reg_waddr", {28'b0, reg_waddr}, 32'd0);
        checkOutput("rst_reg_wdata", reg_wdata, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_abort", {31'b0, abort}, 32'd0);
        Rst = 1'b0;

        applyStimulus(1, 0, 1, 1, 0, 32'h100, 32'h8, 32'h0BAD_F00D, 4'd3, 4'd5, 0, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 0, 0, 0, 32'h203, 32'h3, 32'h1234_5678, 4'd1, 4'd2, 3, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 32'h1000, 32'h2, 32'h0, 4'd7, 4'd7, 1, 32'hAABB_CCDD);

        // Reset while a load is waiting on memory, then carry on normally.
        issueStart(1, 0, 1, 1, 1, 32'h400, 32'h4, 32'h0, 4'd2, 4'd6, e0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        Rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_reg_we", {31'b0, reg_we}, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        Rst = 1'b0;

        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom,
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                          $urandom_range(0, 4), $urandom);
        end

`ifdef LDST_TIMEOUT_EN
        begin
            done_exp_t d;
            issueStart(1, 0, 1, 1, 1, 32'h800, 32'h10, 32'h0, 4'd1, 4'd2, e0);
            d.start_edge = e0;
            d.cycles     = 2 + 16;
            d.abort      = 1'b1;
            done_q.push_back(d);
            waitDone();
        end
        applyStimulus(1, 0, 1, 0, 0, 32'h900, 32'h20, 32'h0, 4'd4, 4'd8, 15, 32'h5555_AAAA);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("mem_q_drained", mem_q.size(), 32'd0);
        checkOutput("reg_q_drained", reg_q.size(), 32'd0);
        checkOutput("done_q_drained", done_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
